// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: sequential combination lock with fail counting, timed lockout
// and key re-programming while open.
module code_lock_ctrl #(
   parameter int DIGITS         = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] digit_in,
   input  logic       digit_valid,
   input  logic       entry_clr,
   input  logic       lock_cmd,
   input  logic       prog_en,
   output logic       unlocked,
   output logic       locked_out,
   output logic       fail,
   output logic       prog_done,
   output logic [2:0] digit_cnt
);
   localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
   typedef enum logic [1:0] {LOCKED, OPEN, PROG, LOCKOUT} state_t;
   state_t state, state_n;
   logic [2:0] cnt_n;
   logic [3:0] fails, fails_n;
   logic [TW-1:0] timer, timer_n;
   logic mis, mis_n, fail_n, done_n, key_we, match, last;
   // Sized to the largest legal DIGITS so a 3-bit count always indexes in range.
   logic [5:0] key [8];
   assign match = &(digit_in ~^ key[digit_cnt]);
   assign last = digit_cnt == 3'(DIGITS - 1);
   assign unlocked = state == OPEN || state == PROG;
   assign locked_out = state == LOCKOUT;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOCKED;
         digit_cnt <= '0;
         fails <= '0;
         timer <= '0;
         mis <= 1'b0;
         fail <= 1'b0;
         prog_done <= 1'b0;
         for (int i = 0; i < 8; i++) key[i] <= '0;
      end else begin
         state <= state_n;
         digit_cnt <= cnt_n;
         fails <= fails_n;
         timer <= timer_n;
         mis <= mis_n;
         fail <= fail_n;
         prog_done <= done_n;
         if (key_we) key[digit_cnt] <= digit_in;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = digit_cnt;
      fails_n = fails;
      timer_n = timer;
      mis_n = mis;
      fail_n = 1'b0;
      done_n = 1'b0;
      key_we = 1'b0;
      case (state)
         LOCKED: begin
            if (entry_clr) begin
               cnt_n = '0;
               mis_n = 1'b0;
            end else if (digit_valid && !last) begin
               cnt_n = digit_cnt + 3'd1;
               mis_n = mis | ~match;
            end else if (digit_valid) begin
               cnt_n = '0;
               mis_n = 1'b0;
               if (!mis && match) begin
                  state_n = OPEN;
                  fails_n = '0;
               end else begin
                  fail_n = 1'b1;
                  fails_n = fails + 4'd1;
                  if (fails + 4'd1 == 4'(MAX_FAILS)) begin
                     state_n = LOCKOUT;
                     timer_n = TW'(LOCKOUT_CYCLES);
                  end
               end
            end
         end
         OPEN: begin
            state_n = lock_cmd ? LOCKED : prog_en ? PROG : OPEN;
            cnt_n = (lock_cmd || prog_en) ? 3'd0 : digit_cnt;
         end
         PROG: begin
            if (entry_clr) begin
               state_n = OPEN;
               cnt_n = '0;
            end else if (digit_valid) begin
               key_we = 1'b1;
               cnt_n = last ? 3'd0 : digit_cnt + 3'd1;
               done_n = last;
               state_n = last ? OPEN : PROG;
            end
         end
         LOCKOUT: begin
            // The cycle that leaves LOCKOUT is the last one counted, giving exactly LOCKOUT_CYCLES.
            timer_n = timer - TW'(1);
            if (timer == TW'(1)) begin
               state_n = LOCKED;
               fails_n = '0;
            end
         end
         default: state_n = LOCKED;
      endcase
   end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed scenarios plus random traffic checked against a
// behavioural lock model every cycle.
module tb_code_lock_ctrl;
   localparam int DIGITS = 4, MAX_FAILS = 3, LOCKOUT_CYCLES = 16;
   logic clk = 0, rst = 1;
   logic [5:0] digit_in = 0;
   logic digit_valid = 0, entry_clr = 0, lock_cmd = 0, prog_en = 0;
   logic unlocked, locked_out, fail, prog_done;
   logic [2:0] digit_cnt;
   int tests = 0, fails_seen = 0;
   code_lock_ctrl #(.DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid), .entry_clr(entry_clr),
      .lock_cmd(lock_cmd), .prog_en(prog_en), .unlocked(unlocked), .locked_out(locked_out),
      .fail(fail), .prog_done(prog_done), .digit_cnt(digit_cnt));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails_seen++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: key list, queue of entered digits, open/prog flags, remaining lockout time.
   logic [5:0] m_key [DIGITS];
   logic [5:0] m_entry [$];
   bit m_open = 0, m_prog = 0, m_valid = 0, m_rst_seen = 0, e_fail = 0, e_done = 0, ok;
   int m_fails = 0, m_lock_left = 0, m_n = 0;
   always @(posedge clk) begin
      e_fail = 0;
      e_done = 0;
      m_rst_seen = rst;
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) m_key[i] = 0;
         m_entry.delete();
         m_open = 0; m_prog = 0; m_fails = 0; m_lock_left = 0; m_n = 0; m_valid = 1;
      end else if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) m_fails = 0;
      end else if (m_prog) begin
         if (entry_clr) begin
            m_prog = 0; m_n = 0;
         end else if (digit_valid) begin
            m_key[m_n] = digit_in;
            m_n++;
            if (m_n == DIGITS) begin m_n = 0; m_prog = 0; e_done = 1; end
         end
      end else if (m_open) begin
         if (lock_cmd) m_open = 0;
         else if (prog_en) begin m_prog = 1; m_n = 0; end
      end else if (entry_clr) m_entry.delete();
      else if (digit_valid) begin
         m_entry.push_back(digit_in);
         if (m_entry.size() == DIGITS) begin
            ok = 1;
            for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_key[i]) ok = 0;
            m_entry.delete();
            if (ok) begin m_open = 1; m_fails = 0; end
            else begin
               e_fail = 1;
               m_fails++;
               if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
            end
         end
      end
   end
   int lo_run = 0;
   always @(negedge clk) if (m_valid) begin
      chk("unlocked", unlocked, m_open || m_prog);
      chk("locked_out", locked_out, m_lock_left > 0);
      chk("fail", fail, e_fail);
      chk("prog_done", prog_done, e_done);
      chk("digit_cnt", digit_cnt, m_prog ? m_n : m_entry.size());
      if (m_rst_seen) lo_run = 0;
      else if (locked_out) lo_run++;
      else if (lo_run > 0) begin
         chk("lockout_len", lo_run, LOCKOUT_CYCLES);
         lo_run = 0;
      end
   end
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic strobe(input logic [5:0] d, input logic clr = 0);
      digit_in = d; digit_valid = 1; entry_clr = clr;
      @(negedge clk);
      digit_valid = 0; entry_clr = 0;
   endtask
   task automatic code(input logic [5:0] a, b, c, d);
      strobe(a); strobe(b); strobe(c); strobe(d);
   endtask
   task automatic pulse_lock();
      lock_cmd = 1; @(negedge clk); lock_cmd = 0;
   endtask
   task automatic pulse_prog();
      prog_en = 1; @(negedge clk); prog_en = 0;
   endtask
   initial begin
      idle(2);
      rst = 0;
      chk("rst_unlocked", unlocked, 0);
      chk("rst_cnt", digit_cnt, 0);
      code(0, 0, 0, 0);
      chk("lit_default_open", unlocked, 1);
      pulse_prog();
      code(5, 63, 0, 42);
      chk("lit_prog_done", prog_done, 1);
      pulse_lock();
      chk("lit_relocked", unlocked, 0);
      code(5, 63, 0, 42);
      chk("lit_new_key_open", unlocked, 1);
      pulse_lock();
      strobe(5); strobe(63); strobe(1);
      chk("lit_no_early_fail", fail, 0);
      chk("lit_cnt3", digit_cnt, 3);
      strobe(42);
      chk("lit_wrong_fail", fail, 1);
      chk("lit_wrong_cnt", digit_cnt, 0);
      code(1, 1, 1, 1);
      code(2, 2, 2, 2);
      chk("lit_lockout", locked_out, 1);
      code(5, 63, 0, 42);
      chk("lit_ignored", unlocked, 0);
      idle(14);
      chk("lit_lockout_end", locked_out, 0);
      code(5, 63, 0, 42);
      chk("lit_after_lockout", unlocked, 1);
      pulse_lock();
      strobe(5); strobe(63); strobe(0, 1);
      chk("lit_clr_cnt", digit_cnt, 0);
      code(5, 63, 0, 42);
      chk("lit_clr_open", unlocked, 1);
      pulse_lock();
      code(9, 9, 9, 9);
      code(9, 9, 9, 9);
      chk("lit_no_lockout", locked_out, 0);
      code(5, 63, 0, 42);
      pulse_prog();
      strobe(7); strobe(8);
      rst = 1; @(negedge clk); rst = 0;
      chk("lit_rst_unlocked", unlocked, 0);
      chk("lit_rst_cnt", digit_cnt, 0);
      code(0, 0, 0, 0);
      chk("lit_rst_key", unlocked, 1);
      for (int i = 0; i < 4000; i++) begin
         rst = $urandom_range(0, 299) == 0;
         digit_valid = $urandom_range(0, 1);
         digit_in = $urandom_range(0, 1);
         entry_clr = $urandom_range(0, 24) == 0;
         lock_cmd = $urandom_range(0, 9) == 0;
         prog_en = $urandom_range(0, 7) == 0;
         @(negedge clk);
      end
      rst = 0; digit_valid = 0; entry_clr = 0; lock_cmd = 0; prog_en = 0;
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails_seen);
      $finish;
   end
endmodule
